// File: rtl/tlc_phase_arbiter.sv
// tlc_phase_arbiter: demand-driven phase scheduler for a four-arm junction plus
// pedestrian crossing. Define TLC_PREEMPT_EN to add the emergency preempt input.
module tlc_phase_arbiter #(
    parameter int CNT_W      = 8,
    parameter int T_MAIN_MIN = 7,
    parameter int T_SVC      = 5,
    parameter int T_PED      = 4,
    parameter int T_YEL      = 2,
    parameter int T_ALLRED   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_s,
    input  logic       req_mt,
    input  logic       req_ped,
`ifdef TLC_PREEMPT_EN
    input  logic       preempt,
`endif
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic       walk,
    output logic [2:0] phase,
    output logic [2:0] pending
);

    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_YEL = 3'd1,
        ALLRED_A = 3'd2,
        SVC_GRN  = 3'd3,
        SVC_YEL  = 3'd4,
        ALLRED_B = 3'd5
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [1:0] SRC_S   = 2'd0;
    localparam logic [1:0] SRC_MT  = 2'd1;
    localparam logic [1:0] SRC_PED = 2'd2;

    localparam logic [CNT_W-1:0] LD_MAIN = CNT_W'(T_MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] LD_SVC  = CNT_W'(T_SVC - 1);
    localparam logic [CNT_W-1:0] LD_PED  = CNT_W'(T_PED - 1);
    localparam logic [CNT_W-1:0] LD_YEL  = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] LD_AR   = CNT_W'(T_ALLRED - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nx;
    logic [1:0]       sel;
    logic [1:0]       sel_nx;
    logic [1:0]       rr;
    logic [1:0]       rr_nx;
    logic [1:0]       pick;
    logic [2:0]       req;
    logic [2:0]       serve;
    logic [2:0]       pend_nx;
    logic             expired;
    logic             pre;
    logic             flash;

`ifdef TLC_PREEMPT_EN
    assign pre = preempt;
`else
    assign pre = 1'b0;
`endif

    assign req     = {req_ped, req_mt, req_s};
    assign expired = (timer == '0);

    // Parity of cycles elapsed in yellow: the flash-walk starts dark.
    assign flash = LD_YEL[0] ^ timer[0];

    // First pending source at or after the round-robin pointer.
    always_comb begin
        pick = SRC_S;
        case (rr)
            SRC_MT:  pick = pending[1] ? SRC_MT :
                            (pending[2] ? SRC_PED : SRC_S);
            SRC_PED: pick = pending[2] ? SRC_PED :
                            (pending[0] ? SRC_S : SRC_MT);
            default: pick = pending[0] ? SRC_S :
                            (pending[1] ? SRC_MT : SRC_PED);
        endcase
    end

    assign serve   = (state == SVC_GRN) ? (3'b001 << sel) : 3'b000;
    assign pend_nx = (pending | req) & ~serve;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= MAIN_GRN;
            timer   <= LD_MAIN;
            pending <= 3'b000;
            rr      <= SRC_S;
            sel     <= SRC_S;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            pending <= pend_nx;
            rr      <= rr_nx;
            sel     <= sel_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        rr_nx    = rr;
        timer_nx = expired ? timer : timer - CNT_W'(1);
        case (state)
            MAIN_GRN: begin
                if (expired && (pending != 3'b000) && !pre) begin
                    state_nx = MAIN_YEL;
                    timer_nx = LD_YEL;
                    sel_nx   = pick;
                    rr_nx    = (pick == SRC_PED) ? SRC_S : pick + 2'd1;
                end
            end
            MAIN_YEL: begin
                if (expired) begin
                    state_nx = ALLRED_A;
                    timer_nx = LD_AR;
                end
            end
            ALLRED_A: begin
                if (expired) begin
                    state_nx = SVC_GRN;
                    timer_nx = (sel == SRC_PED) ? LD_PED : LD_SVC;
                end
            end
            SVC_GRN: begin
                if (expired || pre) begin
                    state_nx = SVC_YEL;
                    timer_nx = LD_YEL;
                end
            end
            SVC_YEL: begin
                if (expired) begin
                    state_nx = ALLRED_B;
                    timer_nx = LD_AR;
                end
            end
            ALLRED_B: begin
                if (expired) begin
                    state_nx = MAIN_GRN;
                    timer_nx = LD_MAIN;
                end
            end
            default: begin
                state_nx = MAIN_GRN;
                timer_nx = LD_MAIN;
            end
        endcase
    end

    always_comb begin
        light_M1 = RED;
        light_M2 = RED;
        light_MT = RED;
        light_S  = RED;
        walk     = 1'b0;
        phase    = state;
        case (state)
            MAIN_GRN: begin
                light_M1 = GRN;
                light_M2 = GRN;
            end
            MAIN_YEL: begin
                light_M1 = YEL;
                light_M2 = YEL;
            end
            ALLRED_A, ALLRED_B: begin
            end
            SVC_GRN: begin
                case (sel)
                    SRC_S:   light_S  = GRN;
                    SRC_MT:  light_MT = GRN;
                    SRC_PED: walk     = 1'b1;
                    default: begin
                    end
                endcase
            end
            SVC_YEL: begin
                case (sel)
                    SRC_S:   light_S  = YEL;
                    SRC_MT:  light_MT = YEL;
                    SRC_PED: walk     = flash;
                    default: begin
                    end
                endcase
            end
            default: begin
                light_M1 = 3'b000;
                light_M2 = 3'b000;
                light_MT = 3'b000;
                light_S  = 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// tb_tlc_phase_arbiter: randomized and directed bench for tlc_phase_arbiter
// against a segment/age reference model of the phase schedule.
module tb_tlc_phase_arbiter;

    localparam int T_MAIN_MIN = 7;
    localparam int T_SVC      = 5;
    localparam int T_PED      = 4;
    localparam int T_YEL      = 2;
    localparam int T_ALLRED   = 1;

    localparam logic [12:0] RST_LT = {3'b001, 3'b001, 3'b100, 3'b100, 1'b0};

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       req_s   = 1'b0;
    logic       req_mt  = 1'b0;
    logic       req_ped = 1'b0;
    logic       preempt = 1'b0;
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic       walk;
    logic [2:0] phase;
    logic [2:0] pending;

    int checks   = 0;
    int failures = 0;

    int         m_phase = 0;
    int         m_age   = 0;
    int         m_sel   = 0;
    int         m_rr    = 0;
    logic [2:0] m_pend  = 3'b000;

    int exp_ph [19] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 2,
                        3, 3, 3, 3, 3, 4, 4, 5, 0};

    tlc_phase_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_s   (req_s),
        .req_mt  (req_mt),
        .req_ped (req_ped),
`ifdef TLC_PREEMPT_EN
        .preempt (preempt),
`endif
        .light_M1(light_M1),
        .light_M2(light_M2),
        .light_MT(light_MT),
        .light_S (light_S),
        .walk    (walk),
        .phase   (phase),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int seg_len(input int ph, input int sl);
        case (ph)
            1, 4:    return T_YEL;
            2, 5:    return T_ALLRED;
            3:       return (sl == 2) ? T_PED : T_SVC;
            default: return T_MAIN_MIN;
        endcase
    endfunction

    // One clock edge of the reference schedule, using the inputs present now.
    task automatic model_step();
        logic [2:0] rq;
        logic [2:0] sv;
        bit         found;
        rq = {req_ped, req_mt, req_s};
        if (!rst_n) begin
            m_phase = 0;
            m_age   = 0;
            m_sel   = 0;
            m_rr    = 0;
            m_pend  = 3'b000;
            return;
        end
        sv = (m_phase == 3) ? (3'b001 << m_sel) : 3'b000;
        if (m_phase == 0) begin
            if (!preempt && m_age >= T_MAIN_MIN - 1 && m_pend != 0) begin
                found = 0;
                for (int i = 0; i < 3; i++) begin
                    int k;
                    k = (m_rr + i) % 3;
                    if (!found && m_pend[k]) begin
                        found = 1;
                        m_sel = k;
                        m_rr  = (k + 1) % 3;
                    end
                end
                m_phase = 1;
                m_age   = 0;
            end else begin
                m_age++;
            end
        end else if (m_age + 1 >= seg_len(m_phase, m_sel) ||
                     (m_phase == 3 && preempt)) begin
            m_phase = (m_phase == 5) ? 0 : m_phase + 1;
            m_age   = 0;
        end else begin
            m_age++;
        end
        m_pend = (m_pend | rq) & ~sv;
    endtask

    function automatic int exp_lights();
        logic [2:0] m;
        logic [2:0] mt;
        logic [2:0] s;
        logic       w;
        m  = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
        mt = 3'b100;
        s  = 3'b100;
        w  = 1'b0;
        if (m_phase == 3) begin
            if (m_sel == 0) s = 3'b001;
            if (m_sel == 1) mt = 3'b001;
            if (m_sel == 2) w = 1'b1;
        end
        if (m_phase == 4) begin
            if (m_sel == 0) s = 3'b010;
            if (m_sel == 1) mt = 3'b010;
            if (m_sel == 2) w = (m_age % 2 == 1);
        end
        return int'({m, m, mt, s, w});
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("phase", int'(phase), m_phase);
        check("pend", int'(pending), int'(m_pend));
        check("lights",
              int'({light_M1, light_M2, light_MT, light_S, walk}),
              exp_lights());
    endtask

    function automatic bit cond(input int kind);
        case (kind)
            0:       return light_S == 3'b001;
            1:       return light_MT == 3'b001;
            2:       return phase == 3'd4;
            3:       return phase == 3'd3;
            4:       return phase == 3'd0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_until(input string tag, input int kind, input int maxc);
        int n;
        n = 0;
        while (!cond(kind) && n < maxc) begin
            tick();
            n++;
        end
        check(tag, int'(cond(kind)), 1);
    endtask

    task automatic do_reset();
        req_s   = 1'b0;
        req_mt  = 1'b0;
        req_ped = 1'b0;
        preempt = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
    endtask

    initial begin
        int order[$];
        int run;
        int prev_ph;
        int s_exp;

        do_reset();
        check("rst_ph", int'(phase), 0);
        check("rst_pend", int'(pending), 0);
        check("rst_lt",
              int'({light_M1, light_M2, light_MT, light_S, walk}),
              int'(RST_LT));

        // Side request held from reset release.
        req_s = 1'b1;
        for (int c = 0; c < 19; c++) begin
            check("seq_ph", int'(phase), exp_ph[c]);
            s_exp = (c >= 10 && c <= 14) ? 1 : (c >= 15 && c <= 16) ? 2 : 4;
            check("seq_S", int'(light_S), s_exp);
            if (c == 5) check("seq_pend_set", int'(pending[0]), 1);
            if (c == 12) check("seq_pend_clr", int'(pending[0]), 0);
            tick();
        end
        req_s = 1'b0;

        do_reset();
        for (int i = 0; i < 100; i++) begin
            check("idle", int'(phase == 0 && light_M1 == 3'b001 &&
                               light_M2 == 3'b001 && pending == 0), 1);
            tick();
        end

        // All three sources pulsed together at cycle 2.
        do_reset();
        run     = 0;
        prev_ph = 0;
        for (int i = 0; i < 100; i++) begin
            {req_ped, req_mt, req_s} = (i == 2) ? 3'b111 : 3'b000;
            if (phase == 3 && prev_ph != 3)
                order.push_back(light_S == 3'b001 ? 0 :
                                light_MT == 3'b001 ? 1 : walk ? 2 : 3);
            if (phase == 1 && prev_ph == 0)
                check("mg_min", int'(run >= T_MAIN_MIN), 1);
            run     = (phase == 0) ? run + 1 : 0;
            prev_ph = int'(phase);
            tick();
        end
        {req_ped, req_mt, req_s} = 3'b000;
        check("ord_n", order.size(), 3);
        for (int i = 0; i < 3; i++)
            check("ord", (i < order.size()) ? order[i] : -1, i);

        // Turn request during its own green vs. its yellow.
        do_reset();
        req_mt = 1'b1;
        tick();
        req_mt = 1'b0;
        run_until("mt_g1", 1, 40);
        tick();
        req_mt = 1'b1;
        tick();
        req_mt = 1'b0;
        check("mt_ign", int'(pending[1]), 0);
        run_until("mt_y", 2, 20);
        req_mt = 1'b1;
        tick();
        req_mt = 1'b0;
        check("mt_lat", int'(pending[1]), 1);
        run_until("mt_g2", 1, 60);

        // Reset in the middle of a side-road green.
        do_reset();
        req_s = 1'b1;
        tick();
        req_s = 1'b0;
        run_until("s_g", 0, 40);
        tick();
        req_s = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_s = 1'b0;
        check("mid_rst_ph", int'(phase), 0);
        check("mid_rst_pend", int'(pending), 0);
        check("mid_rst_lt",
              int'({light_M1, light_M2, light_MT, light_S, walk}),
              int'(RST_LT));

`ifdef TLC_PREEMPT_EN
        do_reset();
        req_s = 1'b1;
        tick();
        req_s = 1'b0;
        run_until("p_g", 3, 40);
        tick();
        preempt = 1'b1;
        tick();
        check("p_cut", int'(phase), 4);
        preempt = 1'b0;
        run_until("p_main", 4, 20);
        req_s   = 1'b1;
        preempt = 1'b1;
        tick();
        req_s = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        check("p_hold", int'(phase == 0 && pending[0]), 1);
        preempt = 1'b0;
        run_until("p_rel", 3, 20);
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req_s   = ($urandom_range(0, 7) == 0);
            req_mt  = ($urandom_range(0, 9) == 0);
            req_ped = ($urandom_range(0, 11) == 0);
            rst_n   = ($urandom_range(0, 399) != 0);
`ifdef TLC_PREEMPT_EN
            if ($urandom_range(0, 29) == 0) preempt = ~preempt;
`endif
            tick();
        end
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
